// File: rtl/round_robin_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   w8          - 8-bit index type used for requester indices and the pointer
//   MAX_REQ     - largest requester count an 8-bit index can address
//   next_ptr()  - pointer advance with wrap after the last requester
package round_robin_arbiter_pkg;

    typedef logic [7:0] w8;

    localparam int MAX_REQ = 255;

    // Priority moves to the requester just after the one granted, wrapping
    // back to 0 after the last requester.
    function automatic w8 next_ptr(input w8 grant, input int n_req);
        return (grant == w8'(n_req - 1)) ? w8'(0) : w8'(grant + w8'(1));
    endfunction

endpackage

// File: rtl/PriorityEncoder.sv
// Lowest-set-bit priority encoder.
// Ports:
//   in_bits - request vector, bit 0 has the highest priority
//   index   - position of the lowest set bit (0 when in_bits is zero)
//   zero    - high when no bit of in_bits is set
module PriorityEncoder
    import round_robin_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] in_bits,
    output w8            index,
    output logic         zero
);

    // Scanning from the top down lets the lowest set bit overwrite any
    // higher one, so the last assignment wins.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path
        // that leaves it unassigned would infer a latch.
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_bits[i]) begin
                index = w8'(i);
            end
        end
    end

    assign zero = ~|in_bits;

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter feeding a single registered output slot.
// Ports:
//   clk         - clock, all state changes on the rising edge
//   nrst        - asynchronous active-low reset
//   req_valid   - per-requester valid
//   req_payload - per-requester payload (unpacked, indexed by requester)
//   req_ready   - one-hot or zero; a requester is accepted on valid & ready
//   out_valid   - output slot holds a transfer
//   out_payload - payload held in the output slot
//   out_src     - requester index that produced the slot contents
//   out_ready   - consumer accepts the slot on out_valid & out_ready
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [PAYLOAD_W-1:0] req_payload [N_REQ],
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output w8                    out_src,
    input  logic                 out_ready
);

    // Requester indices travel in an 8-bit type, so the count must fit.
    if (N_REQ < 1 || N_REQ > MAX_REQ) begin : g_bad_n_req
        $error("round_robin_arbiter: N_REQ must be in 1..255");
    end

    w8                    ptr;
    logic [N_REQ-1:0]     hi_mask;
    logic [N_REQ-1:0]     masked;
    w8                    masked_idx;
    w8                    any_idx;
    logic                 masked_zero;
    logic                 none_valid;
    logic                 any;
    logic                 load;
    w8                    grant;
    logic [PAYLOAD_W-1:0] grant_payload;

    // Requesters at or above the pointer get first pick this cycle.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi_mask[i] = (w8'(i) >= ptr);
        end
    end

    assign masked = req_valid & hi_mask;

    PriorityEncoder #(.N(N_REQ)) u_enc_masked (
        .in_bits (masked),
        .index   (masked_idx),
        .zero    (masked_zero)
    );

    PriorityEncoder #(.N(N_REQ)) u_enc_all (
        .in_bits (req_valid),
        .index   (any_idx),
        .zero    (none_valid)
    );

    // With nobody at or above the pointer, wrap around to the lowest valid.
    assign grant = masked_zero ? any_idx : masked_idx;

    // Gating with nrst keeps req_ready low while reset is held, even though
    // the empty slot would otherwise make load true.
    assign any  = ~none_valid & nrst;
    assign load = ~out_valid | out_ready;

    // Compare against each index instead of indexing by the 8-bit grant so
    // the select width always matches the vector.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = load & any & (grant == w8'(i));
        end
    end

    always_comb begin
        grant_payload = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant == w8'(i)) begin
                grant_payload = req_payload[i];
            end
        end
    end

    // The slot refills on the same edge it drains, giving one transfer per
    // cycle; when nothing is requested only the valid bit clears and the
    // last payload/source stay put.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            ptr         <= '0;
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_src     <= '0;
        end else if (load) begin
            if (any) begin
                out_valid   <= 1'b1;
                out_payload <= grant_payload;
                out_src     <= grant;
                ptr         <= next_ptr(grant, N_REQ);
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter (N_REQ=4, PAYLOAD_W=32).
// A behavioural round-robin model predicts req_ready and pushes the expected
// slot contents into a queue; the queue is popped whenever the DUT drains
// the slot.
module tb_round_robin_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic          clk;
    logic          nrst;
    logic [N-1:0]  req_valid;
    logic [W-1:0]  req_payload [N];
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [W-1:0]  out_payload;
    logic [7:0]    out_src;
    logic          out_ready;

    typedef struct packed {
        logic [7:0]   src;
        logic [W-1:0] payload;
    } xfer_t;

    xfer_t        sb [$];
    int           m_ptr;
    logic         m_valid;
    logic [N-1:0] last_acc;
    int           n_checks;
    int           n_fail;

    round_robin_arbiter #(.N_REQ(N), .PAYLOAD_W(W)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .req_valid   (req_valid),
        .req_payload (req_payload),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_payload (out_payload),
        .out_src     (out_src),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters must hold valid and payload until accepted.
    for (genvar gi = 0; gi < N; gi++) begin : g_proto
        assert property (@(posedge clk) disable iff (!nrst)
            (req_valid[gi] && !req_ready[gi]) |=> (req_valid[gi] && $stable(req_payload[gi])))
            else $error("protocol violation: requester %0d dropped valid or changed payload", gi);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Round robin by searching upward from the pointer with wrap.
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check handshake and scoreboard before the edge, then
    // advance the model. Called and returns at a falling edge.
    task automatic step();
        int           g;
        logic         load;
        logic [N-1:0] exp_ready;
        xfer_t        exp_x;
        #1;
        load = !m_valid || out_ready;
        g = model_grant(req_valid, m_ptr);
        exp_ready = '0;
        if (load && g >= 0) exp_ready[g] = 1'b1;
        last_acc = exp_ready;
        n_checks++;
        if (req_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL step_req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
        end
        n_checks++;
        if (out_valid !== m_valid) begin
            n_fail++;
            $display("FAIL step_out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: got drain of src %0d expected no transfer at %0t", out_src, $time);
            end else begin
                exp_x = sb.pop_front();
                if (out_src !== exp_x.src || out_payload !== exp_x.payload) begin
                    n_fail++;
                    $display("FAIL sb_xfer: got src %0d payload %h expected src %0d payload %h at %0t",
                             out_src, out_payload, exp_x.src, exp_x.payload, $time);
                end
            end
        end
        @(posedge clk);
        if (load) begin
            if (g >= 0) begin
                exp_x.src     = 8'(g);
                exp_x.payload = req_payload[g];
                sb.push_back(exp_x);
                m_valid = 1'b1;
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_ptr   = 0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        nrst      = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_payload[i] = 32'h100 + 32'(i);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        nrst      = 1'b0;
        req_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) req_payload[i] = 32'h100 + 32'(i);
        model_clear();
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++;
        if (out_src !== 8'd0) begin n_fail++; $display("FAIL reset_out_src: got %0d expected 0", out_src); end
        n_checks++;
        if (out_payload !== 32'h0) begin n_fail++; $display("FAIL reset_out_payload: got %h expected 0", out_payload); end
        nrst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ready: got %b expected 0001", req_ready); end
        step();
        n_checks++;
        if (out_src !== 8'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: got src %0d valid %b expected src 0 valid 1", out_src, out_valid);
        end
    endtask

    task automatic test_rotation();
        int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        req_valid = '1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_checks++;
            if (out_src !== 8'(exp_seq[k]) || out_payload !== 32'h100 + 32'(exp_seq[k])) begin
                n_fail++;
                $display("FAIL rotation_%0d: got src %0d payload %h expected src %0d payload %h",
                         k, out_src, out_payload, exp_seq[k], 32'h100 + 32'(exp_seq[k]));
            end
        end
    endtask

    task automatic test_masked_wrap();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0011;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0: got %b expected 0001", req_ready); end
        step();
        n_checks++;
        if (out_src !== 8'd0 || out_payload !== 32'h100) begin
            n_fail++;
            $display("FAIL wrap_grant0: got src %0d payload %h expected src 0 payload 00000100", out_src, out_payload);
        end
        n_checks++;
        if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ready1: got %b expected 0010", req_ready); end
        step();
        n_checks++;
        if (out_src !== 8'd1) begin n_fail++; $display("FAIL wrap_grant1: got src %0d expected 1", out_src); end
    endtask

    task automatic test_stall();
        do_reset();
        req_payload[2] = 32'h0000_DEAD;
        req_payload[3] = 32'h0000_BEEF;
        out_ready = 1'b1;
        req_valid = 4'b0100;
        step();
        out_ready = 1'b0;
        req_valid = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_src !== 8'd2 || out_payload !== 32'h0000_DEAD) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got valid %b src %0d payload %h expected valid 1 src 2 payload 0000dead",
                         k, out_valid, out_src, out_payload);
            end
            n_checks++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready_%0d: got %b expected 0000", k, req_ready); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1000", req_ready); end
        step();
        n_checks++;
        if (out_src !== 8'd3 || out_payload !== 32'h0000_BEEF) begin
            n_fail++;
            $display("FAIL stall_release_load: got src %0d payload %h expected src 3 payload 0000beef", out_src, out_payload);
        end
    endtask

    task automatic test_empty_drain();
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 8'd1) begin
            n_fail++;
            $display("FAIL drain_load: got valid %b src %0d expected valid 1 src 1", out_valid, out_src);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL drain_ptr: got ready %b expected 0100", req_ready); end
        step();
        n_checks++;
        if (out_src !== 8'd2) begin n_fail++; $display("FAIL drain_next: got src %0d expected 2", out_src); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req_valid = '1;
        out_ready = 1'b0;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_src !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_held: got valid %b src %0d expected valid 1 src 0", out_valid, out_src);
        end
        #1;
        nrst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got out_valid %b expected 0", out_valid); end
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0000", req_ready); end
        nrst = 1'b1;
        model_clear();
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_restart_ready: got %b expected 0001", req_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (out_src !== 8'(k)) begin n_fail++; $display("FAIL midrst_order_%0d: got src %0d expected %0d", k, out_src, k); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pending;
        do_reset();
        pending = '0;
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pending[i]) req_payload[i] = $urandom;
            end
            req_valid = pending | N'($urandom);
            step();
            pending = req_valid & ~last_acc;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_acc  = '0;
        nrst      = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_payload[i] = '0;
        test_reset();
        test_rotation();
        test_masked_wrap();
        test_stall();
        test_empty_drain();
        test_mid_reset();
        test_random();
        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Round-robin arbiter with a registered output slot that shares one downstream consumer (memory port, shared functional unit, bus) among up to N_REQ requesters. Each requester and the consumer use valid/ready handshakes. Grants rotate so every persistently requesting port is served within N_REQ grants. Lowest-set-bit selection is done by two `PriorityEncoder` instances.

## Interface
- `N_REQ`, default 4: number of requesters. Range 1..255.
- `PAYLOAD_W`, default 32: payload width in bits.

- `clk` input 1: clock. All state changes on the rising edge.
- `nrst` input 1: asynchronous, active-low reset.
- `req_valid` input N_REQ: request valid, one bit per requester.
- `req_payload` input N_REQ×PAYLOAD_W: per-requester payload, unpacked array indexed by requester.
- `req_ready` output N_REQ: one-hot or zero; the payload of requester g is accepted in any cycle where `req_valid[g] & req_ready[g]`.
- `out_valid` output 1: output slot holds a transfer.
- `out_payload` output PAYLOAD_W: payload held in the output slot.
- `out_src` output w8: index of the requester that produced the slot contents.
- `out_ready` input 1: consumer accepts the slot when `out_valid & out_ready`.

## Operation
- State:
  - `ptr` (w8, range 0..N_REQ-1): highest-priority index.
  - Output slot: `out_valid`, `out_payload`, `out_src`.
- Reset values: `ptr`=0, `out_valid`=0, `out_payload`=0, `out_src`=0, `req_ready`=0.
- Load condition: `load = ~out_valid | out_ready`. The slot is empty, or it is being drained this cycle.
- Arbitration (combinational, every cycle):
  - `hi_mask[i] = (i >= ptr)`.
  - `masked = req_valid & hi_mask`.
  - If `masked` is nonzero, grant g = lowest set bit of `masked`. Otherwise g = lowest set bit of `req_valid`.
  - `any` = `req_valid` is nonzero.
- `req_ready[g] = load & any`. All other bits are 0.
  - `req_ready` depends on `req_valid` and `out_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- On a rising edge where `load`:
  - If `any`: `out_valid`←1, `out_payload`←`req_payload[g]`, `out_src`←g, `ptr`←(g == N_REQ-1 ? 0 : g+1).
  - Else: `out_valid`←0. `out_payload`, `out_src` and `ptr` hold.
- When not `load` (slot full, consumer stalling): all state holds and `req_ready` is all-zero.
- Requester rules: once `req_valid` is asserted it stays high, with `req_payload` stable, until accepted. Dropping it earlier is a protocol violation and is flagged by a bench assertion.
- Consumer rule: `out_payload` and `out_src` are stable while `out_valid & ~out_ready`.
- Fairness: with all requesters continuously valid and `out_ready`=1, grants follow ptr, ptr+1, …, wrapping. No requester waits more than N_REQ accepted transfers.
- N_REQ=1 degenerates to a pipeline register. `ptr` stays 0.

## Timing
- Latency: a request accepted at edge t appears on `out_valid` immediately after edge t, i.e. visible during cycle t+1.
- Throughput: one transfer per cycle. A drain and a refill happen on the same edge when `out_valid & out_ready & any`.
- Stall: `out_ready`=0 with `out_valid`=1 holds the slot. The pending grant choice is recomputed each cycle, but `ptr` does not move.
- Simultaneous events:
  - A new requester raising valid in the same cycle as a load is eligible that cycle.
  - A drain with no new request empties the slot (`out_valid`→0 at the next edge).
- Wrap: a grant at g = N_REQ-1 sets `ptr`=0.
- Reset mid-operation: asserting `nrst` low clears the slot and `ptr` immediately (asynchronous). Any held transfer is dropped. `req_ready` drops to 0 combinationally because `out_valid`=0 but `any` is gated by reset. The first grant after deassertion uses `ptr`=0.

## Structure
- Widths use `w8` from `typedefs.svh`. No new package types are required; `N_REQ` ≤ 255 is guaranteed by an elaboration-time check.
- Two instances of the existing sub-module `PriorityEncoder #(N_REQ)`:
  - one on `masked`;
  - one on `req_valid`, whose `zero` output gives `~any`.
- Mask generation, the `ptr` register, the payload mux and the output slot live in this module.

## Test plan
- Reset and idle: hold `nrst`=0 with `req_valid`=4'b1111 → `out_valid`=0, `req_ready`=0, `out_src`=0. Release reset → first grant is to requester 0.
- Rotation: N_REQ=4, all valid continuously, payload[i]=0x100+i, `out_ready`=1 → `out_src` sequence 0,1,2,3,0,1 on consecutive cycles, with matching payloads.
- Masked wrap: `ptr`=3 (after a grant to 2), `req_valid`=4'b0011 → grant 0, then `ptr`=1, next grant 1.
- Stall: slot holds src 2 payload 0xDEAD, `out_ready`=0 for 5 cycles with `req_valid`=4'b1011 → slot unchanged, `req_ready`=0 throughout. Raise `out_ready` → same edge loads requester 3.
- Empty drain: single request from 1, then `req_valid`=0, `out_ready`=1 → one transfer (src 1), then `out_valid`=0, `ptr`=2.
- Mid-transfer reset: `out_valid`=1, stalled; pulse `nrst` low between edges → `out_valid`=0 immediately. After release, with all valid, grant order restarts at 0.
